// File: rtl/tick_period_monitor.sv
// Measures the clk-cycle interval between heartbeat tick rising edges and checks it
// against EXPECTED_PERIOD +/- TOLERANCE, with lock tracking, timeout and error count.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for the first edge, nothing measured yet
// MEASURE | counting cycles since the last edge
// TIMEOUT | edge overdue; counter frozen until the next edge
module tick_period_monitor #(
    parameter int COUNT_WIDTH     = 26,
    parameter int EXPECTED_PERIOD = 16777217,
    parameter int TOLERANCE       = 16,
    parameter int LOCK_COUNT      = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   tick_in,
    input  logic                   clear,
    output logic [COUNT_WIDTH-1:0] period,
    output logic                   period_valid,
    output logic                   in_range,
    output logic                   locked,
    output logic                   timeout,
    output logic [7:0]             error_count
);

    localparam logic [COUNT_WIDTH-1:0] RANGE_LO = COUNT_WIDTH'(EXPECTED_PERIOD - TOLERANCE);
    localparam logic [COUNT_WIDTH-1:0] RANGE_HI = COUNT_WIDTH'(EXPECTED_PERIOD + TOLERANCE);
    // LIMIT-1: the counter value at which a missing edge becomes a timeout
    localparam logic [COUNT_WIDTH-1:0] LIMIT_M1 = COUNT_WIDTH'(EXPECTED_PERIOD + TOLERANCE);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);
    localparam logic [3:0]             LOCK_C   = 4'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        TIMEOUT = 2'd2
    } state_t;

    state_t                 state;
    logic                   tick_q;
    logic [COUNT_WIDTH-1:0] cnt;
    logic [3:0]             lock_run;

    logic       rise;
    logic       cnt_ok;
    logic [4:0] lock_next;
    logic [7:0] err_inc;

    assign rise      = tick_in & ~tick_q;
    assign cnt_ok    = (cnt >= RANGE_LO) && (cnt <= RANGE_HI);
    assign lock_next = {1'b0, lock_run} + 5'd1;
    assign err_inc   = (error_count == 8'hFF) ? error_count : error_count + 8'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            tick_q       <= 1'b0;
            cnt          <= '0;
            lock_run     <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            in_range     <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
            error_count  <= '0;
        end else begin
            tick_q       <= tick_in;
            period_valid <= 1'b0;
            if (clear) begin
                // a coincident edge becomes the first edge of the new run
                lock_run    <= '0;
                locked      <= 1'b0;
                timeout     <= 1'b0;
                in_range    <= 1'b0;
                error_count <= '0;
                if (rise) begin
                    state <= MEASURE;
                    cnt   <= CNT_ONE;
                end else begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (rise) begin
                            state <= MEASURE;
                            cnt   <= CNT_ONE;
                        end
                    end
                    MEASURE: begin
                        if (rise) begin
                            cnt          <= CNT_ONE;
                            period       <= cnt;
                            period_valid <= 1'b1;
                            in_range     <= cnt_ok;
                            if (cnt_ok) begin
                                lock_run <= (lock_next >= 5'(LOCK_COUNT)) ? LOCK_C : lock_next[3:0];
                                locked   <= (lock_next >= 5'(LOCK_COUNT));
                            end else begin
                                lock_run    <= '0;
                                locked      <= 1'b0;
                                error_count <= err_inc;
                            end
                        end else if (cnt == LIMIT_M1) begin
                            state       <= TIMEOUT;
                            timeout     <= 1'b1;
                            locked      <= 1'b0;
                            in_range    <= 1'b0;
                            lock_run    <= '0;
                            error_count <= err_inc;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    TIMEOUT: begin
                        if (rise) begin
                            state   <= MEASURE;
                            cnt     <= CNT_ONE;
                            timeout <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/tick_period_monitor.md
Name: tick_period_monitor

Overview:
- Consumer end of the LED heartbeat tick: measures the interval between tick pulses from a clock divider and checks it against an expected period.
- Reports the last measured period, in-range/lock status, a missing-tick timeout and a saturating error count.
- Used on the DDR3 test board to confirm that the fabric clock and heartbeat are alive and correct. Drives LEDs and debug registers.

Parameters:
- COUNT_WIDTH, 26: width of the interval counter and the period output. Must hold EXPECTED_PERIOD+TOLERANCE+1.
- EXPECTED_PERIOD, 16777217: nominal clk cycles between tick rising edges (2^24+1).
- TOLERANCE, 16: allowed deviation in cycles, either side of EXPECTED_PERIOD.
- LOCK_COUNT, 4: consecutive in-range periods required to assert locked (range 1..15).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- tick_in  input  1  heartbeat tick, synchronous to clk, active high
- clear  input  1  synchronous; restarts monitoring and zeroes error_count
- period  output  COUNT_WIDTH  last measured interval in clk cycles
- period_valid  output  1  one-cycle strobe when period is updated
- in_range  output  1  last measured period within EXPECTED_PERIOD±TOLERANCE
- locked  output  1  LOCK_COUNT consecutive in-range periods seen
- timeout  output  1  no tick edge within EXPECTED_PERIOD+TOLERANCE cycles
- error_count  output  8  saturating count of out-of-range periods plus timeouts

Behaviour:
- Reset: clk is the clock; reset_n is asynchronous, active-low.
  - All outputs reset to 0.
  - tick_q, the interval counter (cnt) and lock_run reset to 0.
  - State resets to IDLE.
- Edge detect: tick_q <= tick_in every cycle; rise = tick_in & ~tick_q. A level held high counts as one edge. There is no synchronizer; tick_in must already be in the clk domain.
- Interval counter:
  - On a rise cycle, cnt <= 1.
  - Otherwise in MEASURE, cnt <= cnt+1.
  - cnt never exceeds LIMIT = EXPECTED_PERIOD+TOLERANCE+1.
  - Period between rises at cycles t0 and t1 is t1-t0, which equals cnt sampled at t1.
- States:
  - IDLE:
    - Waiting for the first edge; cnt holds 0.
    - rise -> MEASURE, cnt=1. No period is reported for the first edge.
  - MEASURE, on rise:
    - period <= cnt; period_valid=1 on the next cycle (registered, latency 1 from the rise cycle).
    - in_range <= (cnt >= EXPECTED_PERIOD-TOLERANCE) && (cnt <= EXPECTED_PERIOD+TOLERANCE).
    - If in range: lock_run <= min(lock_run+1, LOCK_COUNT); locked <= (lock_run+1 >= LOCK_COUNT).
    - If out of range: lock_run <= 0, locked <= 0, error_count++.
    - Stay in MEASURE.
  - MEASURE, no rise and cnt == LIMIT-1 (next cycle would reach LIMIT):
    - Go to TIMEOUT.
    - timeout <= 1, locked <= 0, in_range <= 0, lock_run <= 0, error_count++.
  - TIMEOUT:
    - cnt frozen; timeout held at 1.
    - rise -> MEASURE, cnt=1, timeout <= 0. No period is reported, because the interval is invalid.
- error_count saturates at 8'hFF. Increments are never lost below saturation.
- period and in_range hold their values between strobes.
- clear:
  - Goes to IDLE; lock_run, locked, timeout, in_range and error_count all <= 0.
  - period is held.
  - clear has priority over rise. If rise and clear occur in the same cycle, the rise is taken as the first edge: MEASURE, cnt=1.
- Async reset mid-interval: immediate return to the reset state. The first edge after reset is not measured.
- Back-to-back ticks (tick_in toggling every cycle) give period=2 and are judged against the range like any other period.

Test Plan:
Bench overrides: COUNT_WIDTH=8, EXPECTED_PERIOD=10, TOLERANCE=1, LOCK_COUNT=3 (LIMIT=12).
1. Reset, then one-cycle ticks every 10 cycles × 5 -> no strobe on the first tick; then four strobes with period=10, in_range=1; locked rises one cycle after the 4th tick (3rd period); error_count=0.
2. Locked, then intervals 9, 11, 12 -> first two in range with locked held; 12 gives in_range=0, locked=0, error_count=1.
3. Locked, then tick stops -> timeout=1 exactly 11 cycles after the last rise (cnt would reach 12); locked=0; error_count+1. Next tick gives timeout=0 and no period_valid. The following tick at +10 gives period=10.
4. tick_in held high for 30 cycles after a prior edge -> only one rise counted; timeout as in scenario 3; no extra periods.
5. Force 300 out-of-range periods (interval 5) -> error_count saturates at 255; clear -> error_count=0, state IDLE; clear coincident with a tick -> that tick is the first edge, next tick at +10 gives period=10.
6. Assert reset_n low mid-interval (cnt=6) -> all outputs 0 immediately; the next tick produces no strobe; a tick 10 cycles later gives period=10.
